// File: rtl/timer_cmp_irq.sv
// Multi-channel compare/interrupt unit with sticky status, overrun and priority-encoded int_id.
// Periodic auto-reload (prd registers, mode_periodic) is built only with TIMER_CMP_PERIODIC_EN.
module timer_cmp_irq #(
  parameter int unsigned CNT_W  = 64,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [CNT_W-1:0]        cnt_val,
  input  logic [NUM_CH-1:0]       cmp_we,
  input  logic [CNT_W-1:0]        cmp_wdata,
  input  logic [NUM_CH-1:0]       prd_we,
  input  logic [CNT_W-1:0]        prd_wdata,
  input  logic [NUM_CH-1:0]       mode_periodic,
  input  logic [NUM_CH-1:0]       int_en,
  input  logic [NUM_CH-1:0]       int_clr,
  output logic [NUM_CH*CNT_W-1:0] cmp_val,
  output logic [NUM_CH-1:0]       int_status,
  output logic [NUM_CH-1:0]       int_overrun,
  output logic                    tim_int,
  output logic [ID_W-1:0]         int_id
);

  logic [CNT_W-1:0]  cmp_q [NUM_CH];
  logic [CNT_W-1:0]  cmp_d [NUM_CH];
  logic [NUM_CH-1:0] match, evt, match_q;
  logic [NUM_CH-1:0] status_q, status_d, ovr_q, ovr_d;
  logic [NUM_CH-1:0] pending;

`ifdef TIMER_CMP_PERIODIC_EN
  logic [CNT_W-1:0] prd_q [NUM_CH];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) prd_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (prd_we[i]) prd_q[i] <= prd_wdata;
      end
    end
  end
`else
  logic unused_prd;
  assign unused_prd = ^{prd_we, prd_wdata, mode_periodic};
`endif

  always_comb begin
    match    = '0;
    evt      = '0;
    status_d = status_q;
    ovr_d    = ovr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      match[i] = (cnt_val == cmp_q[i]);
      // Edge detect: a halted counter sitting on cmp raises a single event.
      evt[i]   = match[i] & ~match_q[i];

      if (evt[i])          status_d[i] = 1'b1;
      else if (int_clr[i]) status_d[i] = 1'b0;

      if (evt[i] & status_q[i] & ~int_clr[i]) ovr_d[i] = 1'b1;
      else if (int_clr[i])                    ovr_d[i] = 1'b0;

      cmp_d[i] = cmp_q[i];
      if (cmp_we[i]) begin
        cmp_d[i] = cmp_wdata;
`ifdef TIMER_CMP_PERIODIC_EN
      end else if (evt[i] & mode_periodic[i]) begin
        cmp_d[i] = cmp_q[i] + prd_q[i];
`endif
      end
    end
  end

  // match_q resets high so cnt_val == cmp == 0 after reset is not an event.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      match_q  <= '1;
      status_q <= '0;
      ovr_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) cmp_q[i] <= '0;
    end else begin
      match_q  <= match;
      status_q <= status_d;
      ovr_q    <= ovr_d;
      for (int i = 0; i < NUM_CH; i++) cmp_q[i] <= cmp_d[i];
    end
  end

  assign pending     = status_q & int_en;
  assign int_status  = status_q;
  assign int_overrun = ovr_q;
  assign tim_int     = |pending;

  always_comb begin
    int_id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) int_id = ID_W'(i);
    end
  end

  always_comb begin
    cmp_val = '0;
    for (int i = 0; i < NUM_CH; i++) cmp_val[i*CNT_W +: CNT_W] = cmp_q[i];
  end

endmodule

// File: tb/tb_timer_cmp_irq.sv
// Scoreboard bench for timer_cmp_irq (CNT_W=8, NUM_CH=4); expectations track TIMER_CMP_PERIODIC_EN.
module tb_timer_cmp_irq;
  localparam int CW = 8;
  localparam int NC = 4;
  localparam int IW = 2;
`ifdef TIMER_CMP_PERIODIC_EN
  localparam bit PER = 1'b1;
`else
  localparam bit PER = 1'b0;
`endif

  localparam int KStat = 0, KOvr = 1, KTim = 2, KId = 3, KCmp = 4, KStatAll = 5, KOvrAll = 6;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic [CW-1:0]    cnt_val, cmp_wdata, prd_wdata;
  logic [NC-1:0]    cmp_we, prd_we, mode_periodic, int_en, int_clr;
  logic [NC*CW-1:0] cmp_val;
  logic [NC-1:0]    int_status, int_overrun;
  logic             tim_int;
  logic [IW-1:0]    int_id;

  timer_cmp_irq #(.CNT_W(CW), .NUM_CH(NC), .ID_W(IW)) u_dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .cnt_val      (cnt_val),
    .cmp_we       (cmp_we),
    .cmp_wdata    (cmp_wdata),
    .prd_we       (prd_we),
    .prd_wdata    (prd_wdata),
    .mode_periodic(mode_periodic),
    .int_en       (int_en),
    .int_clr      (int_clr),
    .cmp_val      (cmp_val),
    .int_status   (int_status),
    .int_overrun  (int_overrun),
    .tim_int      (tim_int),
    .int_id       (int_id)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string       tag;
    int          kind;
    int          ch;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic exp_push(input string tag, input int kind, input int ch, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.ch = ch; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        KStat:    got = 32'(int_status[e.ch]);
        KOvr:     got = 32'(int_overrun[e.ch]);
        KTim:     got = 32'(tim_int);
        KId:      got = 32'(int_id);
        KCmp:     got = 32'(cmp_val[e.ch*CW +: CW]);
        KStatAll: got = 32'(int_status);
        default:  got = 32'(int_overrun);
      endcase
      check(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    drain();
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    cnt_val = '0; cmp_wdata = '0; prd_wdata = '0;
    cmp_we = '0; prd_we = '0; mode_periodic = '0; int_en = '0; int_clr = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic write_cmp(input logic [NC-1:0] ch, input logic [CW-1:0] v);
    cmp_we = ch; cmp_wdata = v;
    tick();
    cmp_we = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    do_reset();
    exp_push("rst_status", KStatAll, 0, 0);
    exp_push("rst_ovr", KOvrAll, 0, 0);
    exp_push("rst_tim", KTim, 0, 0);
    exp_push("rst_id", KId, 0, 0);
    exp_push("rst_cmp0", KCmp, 0, 0);
    tick();

    // One-shot on ch0
    do_reset();
    int_en = 4'b0001;
    write_cmp(4'b0001, 8'd10);
    for (int c = 1; c <= 10; c++) begin
      cnt_val = CW'(c);
      if (c == 9) exp_push("os_pre", KStat, 0, 0);
      if (c == 10) begin
        exp_push("os_status", KStat, 0, 1);
        exp_push("os_tim", KTim, 0, 1);
        exp_push("os_id", KId, 0, 0);
        exp_push("os_cmp", KCmp, 0, 10);
      end
      tick();
    end

    // Periodic ch1 with clear after each event
    do_reset();
    int_en = 4'b0010; mode_periodic = 4'b0010;
    prd_we = 4'b0010; prd_wdata = 8'd7;
    write_cmp(4'b0010, 8'd5);
    prd_we = '0;
    for (int c = 1; c <= 20; c++) begin
      bit ev;
      ev = PER ? (c == 5 || c == 12 || c == 19) : (c == 5);
      cnt_val = CW'(c);
      int_clr = (c == 6 || c == 13 || c == 20) ? 4'b0010 : 4'b0000;
      exp_push("per_status", KStat, 1, 32'(ev));
      if (c == 5) exp_push("per_cmp", KCmp, 1, PER ? 12 : 5);
      if (c == 5) exp_push("per_id", KId, 0, 1);
      tick();
    end
    int_clr = '0;

    // Overrun and clear race on ch1
    do_reset();
    int_en = 4'b0010; mode_periodic = 4'b0010;
    prd_we = 4'b0010; prd_wdata = 8'd7;
    write_cmp(4'b0010, 8'd5);
    prd_we = '0;
    for (int c = 1; c <= 19; c++) begin
      cnt_val = CW'(c);
      int_clr = (c == 19) ? 4'b0010 : 4'b0000;
      if (c == 5)  exp_push("ovr_first", KOvr, 1, 0);
      if (c == 12) exp_push("ovr_set", KOvr, 1, PER ? 1 : 0);
      if (c == 19) begin
        exp_push("race_status", KStat, 1, PER ? 1 : 0);
        exp_push("race_ovr", KOvr, 1, 0);
        exp_push("race_cmp", KCmp, 1, PER ? 26 : 5);
      end
      tick();
    end
    int_clr = '0;

    // Wrap on ch0: 250 + 10 -> 4
    do_reset();
    int_en = 4'b0001; mode_periodic = 4'b0001;
    prd_we = 4'b0001; prd_wdata = 8'd10;
    write_cmp(4'b0001, 8'd250);
    prd_we = '0;
    for (int n = 1; n <= 260; n++) begin
      cnt_val = CW'(n);
      int_clr = (n == 251) ? 4'b0001 : 4'b0000;
      if (n == 250) begin
        exp_push("wrap_ev", KStat, 0, 1);
        exp_push("wrap_cmp", KCmp, 0, PER ? 4 : 250);
      end
      if (n == 259) exp_push("wrap_pre", KStat, 0, 0);
      if (n == 260) begin
        exp_push("wrap_ev2", KStat, 0, PER ? 1 : 0);
        exp_push("wrap_cmp2", KCmp, 0, PER ? 14 : 250);
      end
      tick();
    end
    int_clr = '0;

    // Halted counter, one-shot clear race, priority
    do_reset();
    int_en = 4'b1101;
    write_cmp(4'b0001, 8'd10);
    write_cmp(4'b1000, 8'd13);
    write_cmp(4'b0100, 8'd15);
    for (int c = 1; c <= 10; c++) begin
      cnt_val = CW'(c);
      if (c == 10) begin
        exp_push("halt_ev", KStat, 0, 1);
        exp_push("halt_tim", KTim, 0, 1);
      end
      tick();
    end
    for (int h = 0; h < 4; h++) begin
      int_clr = (h == 1) ? 4'b0001 : 4'b0000;
      exp_push("halt_hold", KStat, 0, (h == 0) ? 1 : 0);
      exp_push("halt_ovr", KOvr, 0, 0);
      tick();
    end
    for (int c = 11; c <= 15; c++) begin
      cnt_val = CW'(c);
      int_clr = (c == 15) ? 4'b0100 : 4'b0000;
      if (c == 13) exp_push("prio_id3", KId, 0, 3);
      if (c == 15) begin
        exp_push("clr_race_st", KStat, 2, 1);
        exp_push("clr_race_ovr", KOvr, 2, 0);
        exp_push("prio_all", KStatAll, 0, 4'b1100);
        exp_push("prio_id2", KId, 0, 2);
      end
      tick();
    end
    int_clr = '0;
    int_en = 4'b1000;
    #1;
    exp_push("en_id3", KId, 0, 3);
    exp_push("en_tim", KTim, 0, 1);
    drain();
    int_en = 4'b0000;
    #1;
    exp_push("dis_tim", KTim, 0, 0);
    exp_push("dis_id", KId, 0, 0);
    exp_push("dis_status", KStatAll, 0, 4'b1100);
    drain();
    int_en = 4'b1111;

    // Asynchronous reset mid-cycle, then quiet release with cnt_val = cmp = 0
    #2;
    sys_rst_n = 1'b0;
    #1;
    exp_push("arst_status", KStatAll, 0, 0);
    exp_push("arst_ovr", KOvrAll, 0, 0);
    exp_push("arst_tim", KTim, 0, 0);
    exp_push("arst_id", KId, 0, 0);
    exp_push("arst_cmp2", KCmp, 2, 0);
    exp_push("arst_cmp3", KCmp, 3, 0);
    drain();
    cnt_val = '0;
    tick();
    sys_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_push("rel_status", KStatAll, 0, 0);
      exp_push("rel_tim", KTim, 0, 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
